pc_fetch_ctrl: RTL and testbench

Fetch sequencer for the KLP32 RV32I core. It owns the program counter and chooses the next PC: sequential PC+4, or the execute-stage ALU target. This is the same PC/ALU selection the pc_select_mux datapath performs, and the block drives that mux's select (pc_sel). It also runs a single-outstanding request/grant/response handshake to instruction memory and presents fetched instructions to decode with stall back-pressure and redirect flushing.

---
 rtl/pc_fetch_if.sv | 37 +++
 rtl/pc_fetch_ctrl.sv | 118 +++++++++++
 tb/tb_pc_fetch_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_if.sv
// Fetch-side bus bundle: execute redirect, decode hand-off and the
// instruction-memory request/grant/response channel.
interface pc_fetch_if #(
  parameter int XLEN = 32
);
  // execute / decode side
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            pc_sel;
  logic [XLEN-1:0] pc;
  logic            instr_valid;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;
  // instruction memory side
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  // Fetch controller view
  modport master (
    input  stall, redirect_valid, redirect_target,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output pc_sel, pc, instr_valid, instr, instr_pc,
    output imem_req, imem_addr
  );

  // Environment view (core pipeline + instruction memory)
  modport slave (
    output stall, redirect_valid, redirect_target,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  pc_sel, pc, instr_valid, instr, instr_pc,
    input  imem_req, imem_addr
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, picks PC+4 or the execute-stage target,
// runs a single-outstanding imem handshake and holds the fetched word
// for decode until it is consumed or flushed by a redirect.
module pc_fetch_ctrl #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  pc_fetch_if.master  bus
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic            discard_reg, discard_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic            instr_valid_reg, instr_valid_next;
  logic [31:0]     instr_reg, instr_next;
  logic [XLEN-1:0] instr_pc_reg, instr_pc_next;

  logic            redirect;
  logic            rsp_in_wait;
  logic            accept;
  logic [XLEN-1:0] target_aligned;
  logic [XLEN-1:0] pc_plus4;

  assign redirect       = bus.redirect_valid;
  assign target_aligned = {bus.redirect_target[XLEN-1:2], 2'b00};
  assign pc_plus4       = pc_reg + XLEN'(4);
  // A response only counts while waiting; a live (non-discarded) one
  // becomes the decode instruction unless a redirect flushes it.
  assign rsp_in_wait    = (state_reg == ST_WAIT) && bus.imem_rvalid;
  assign accept         = rsp_in_wait && !discard_reg && !redirect;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_BOOT;
      discard_reg     <= 1'b0;
      pc_reg          <= RESET_VECTOR;
      instr_valid_reg <= 1'b0;
      instr_reg       <= '0;
      instr_pc_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      discard_reg     <= discard_next;
      pc_reg          <= pc_next;
      instr_valid_reg <= instr_valid_next;
      instr_reg       <= instr_next;
      instr_pc_reg    <= instr_pc_next;
    end
  end

  // Next-state logic including the in-flight discard flag.
  always_comb begin
    state_next   = state_reg;
    discard_next = discard_reg;
    unique case (state_reg)
      ST_BOOT: state_next = ST_REQ;
      ST_REQ: begin
        if (bus.imem_gnt) begin
          state_next   = ST_WAIT;
          // The granted request already carries the old address.
          discard_next = redirect;
        end
      end
      ST_WAIT: begin
        if (bus.imem_rvalid) begin
          discard_next = 1'b0;
          state_next   = (redirect || discard_reg) ? ST_REQ : ST_HOLD;
        end else if (redirect) begin
          discard_next = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect || !bus.stall) state_next = ST_REQ;
      end
      default: state_next = ST_BOOT;
    endcase
  end

  // PC and decode-register updates; a redirect beats everything else.
  always_comb begin
    pc_next          = pc_reg;
    instr_valid_next = instr_valid_reg;
    instr_next       = instr_reg;
    instr_pc_next    = instr_pc_reg;
    if (redirect) begin
      pc_next          = target_aligned;
      instr_valid_next = 1'b0;
    end else if (accept) begin
      pc_next          = pc_plus4;
      instr_valid_next = 1'b1;
      instr_next       = bus.imem_rdata;
      instr_pc_next    = pc_reg;
    end else if (state_reg == ST_HOLD && !bus.stall) begin
      instr_valid_next = 1'b0;
    end
  end

  // Outputs: request strobe from state, address and mux select combinational.
  always_comb begin
    bus.imem_req    = (state_reg == ST_REQ);
    bus.imem_addr   = pc_reg;
    bus.pc_sel      = redirect & rst_n;
    bus.pc          = pc_reg;
    bus.instr_valid = instr_valid_reg;
    bus.instr       = instr_reg;
    bus.instr_pc    = instr_pc_reg;
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: inputs change on the falling edge,
// outputs are checked on the falling edge after the rising edge acts.
module tb_pc_fetch_ctrl;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  pc_fetch_if #(.XLEN(32)) bus ();

  pc_fetch_ctrl #(.XLEN(32), .RESET_VECTOR(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog timeout obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full fetch starting in REQ: grant, response, consume without stall.
  task automatic fetch(input logic [31:0] rdata, input logic [31:0] exp_pc);
    logic [31:0] nxt;
    nxt = exp_pc + 32'd4;
    chk("fetch_req", {31'b0, bus.imem_req}, 32'd1);
    chk("fetch_addr", bus.imem_addr, exp_pc);
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_gnt = 1'b0;
    chk("wait_req_low", {31'b0, bus.imem_req}, 32'd0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = rdata;
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    chk("hold_valid", {31'b0, bus.instr_valid}, 32'd1);
    chk("hold_instr", bus.instr, rdata);
    chk("hold_instr_pc", bus.instr_pc, exp_pc);
    chk("hold_pc", bus.pc, nxt);
    chk("hold_pc_sel", {31'b0, bus.pc_sel}, 32'd0);
    @(negedge clk);
    chk("consumed_valid", {31'b0, bus.instr_valid}, 32'd0);
    $display("fetch pc=%h instr=%h", exp_pc, rdata);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0040;
    bus.imem_gnt        = 1'b0;
    bus.imem_rvalid     = 1'b0;
    bus.imem_rdata      = 32'h0;

    // Reset for 3 cycles, with a redirect asserted to prove pc_sel is masked.
    repeat (3) @(negedge clk);
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_pc_sel", {31'b0, bus.pc_sel}, 32'd0);
    bus.redirect_valid = 1'b0;
    rst_n = 1'b1;
    $display("reset released");
    #1;
    chk("boot_req", {31'b0, bus.imem_req}, 32'd0);
    @(negedge clk);

    // First fetch after boot, then sequential fetches.
    fetch(32'h0020_0113, 32'h0000_0000);
    fetch(32'h0010_0093, 32'h0000_0004);
    fetch(32'h0051_0193, 32'h0000_0008);
    fetch(32'h0000_8067, 32'h0000_000C);

    // Stall hold for 5 cycles at pc 0x10.
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h00A0_0513;
    bus.stall       = 1'b1;
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'b0, bus.instr_valid}, 32'd1);
      chk("stall_instr", bus.instr, 32'h00A0_0513);
      chk("stall_instr_pc", bus.instr_pc, 32'h0000_0010);
      chk("stall_req", {31'b0, bus.imem_req}, 32'd0);
      @(negedge clk);
    end
    bus.stall = 1'b0;
    @(negedge clk);
    chk("unstall_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("unstall_req", {31'b0, bus.imem_req}, 32'd1);
    chk("unstall_addr", bus.imem_addr, 32'h0000_0014);
    $display("stall hold done");

    // Redirect while the response is pending.
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_gnt        = 1'b0;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0103;
    #1;
    chk("redir_wait_pc_sel", {31'b0, bus.pc_sel}, 32'd1);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    chk("redir_wait_pc", bus.pc, 32'h0000_0100);
    chk("redir_wait_req", {31'b0, bus.imem_req}, 32'd0);
    @(negedge clk);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    chk("late_rsp_dropped", {31'b0, bus.instr_valid}, 32'd0);
    chk("late_rsp_req", {31'b0, bus.imem_req}, 32'd1);
    chk("late_rsp_addr", bus.imem_addr, 32'h0000_0100);
    chk("late_rsp_pc", bus.pc, 32'h0000_0100);
    $display("redirect in wait done");

    // Redirect coincident with rvalid, stall asserted.
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_gnt        = 1'b0;
    bus.imem_rvalid     = 1'b1;
    bus.imem_rdata      = 32'h1234_5678;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0200;
    bus.stall           = 1'b1;
    @(negedge clk);
    bus.imem_rvalid    = 1'b0;
    bus.redirect_valid = 1'b0;
    chk("coinc_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("coinc_pc", bus.pc, 32'h0000_0200);
    chk("coinc_req", {31'b0, bus.imem_req}, 32'd1);
    chk("coinc_addr", bus.imem_addr, 32'h0000_0200);

    // Redirect while holding under stall.
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h1111_1111;
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    chk("hold_stall_valid", {31'b0, bus.instr_valid}, 32'd1);
    chk("hold_stall_pc", bus.pc, 32'h0000_0204);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0302;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.stall          = 1'b0;
    chk("hold_redir_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("hold_redir_pc", bus.pc, 32'h0000_0300);
    chk("hold_redir_req", {31'b0, bus.imem_req}, 32'd1);
    $display("redirect in hold done");

    // Redirect in REQ without grant, then fetch at the top of memory.
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    fetch(32'h0000_0013, 32'hFFFF_FFFC);
    chk("wrap_pc", bus.pc, 32'h0000_0000);

    // Async reset mid-WAIT, checked before any clock edge.
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_gnt = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_pc", bus.pc, 32'h0);
    chk("async_instr", bus.instr, 32'h0);
    chk("async_instr_pc", bus.instr_pc, 32'h0);
    chk("async_req", {31'b0, bus.imem_req}, 32'd0);
    chk("async_valid", {31'b0, bus.instr_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hCAFE_F00D;
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    chk("post_rst_rsp_ignored", {31'b0, bus.instr_valid}, 32'd0);
    chk("post_rst_req", {31'b0, bus.imem_req}, 32'd1);
    chk("post_rst_addr", bus.imem_addr, 32'h0);
    $display("async reset done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
